// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver:
// FSM state encoding, sample-point positions and the tick divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam int unsigned OVERSAMPLE = 16;

  // Positions within a bit (sample counter values) used for voting and bit end.
  localparam logic [3:0] S_VOTE_A = 4'd7;
  localparam logic [3:0] S_VOTE_B = 4'd8;
  localparam logic [3:0] S_VOTE_C = 4'd9;
  localparam logic [3:0] S_END    = 4'd15;

  function automatic int unsigned calc_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clock_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversampling tick divider: one-clock tick every DIV clocks, with a
// synchronous restart so the sample phase can be aligned to a start edge.
module uart_os_tick_gen #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = (cnt_q == LAST);
    if (restart || tick) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: synchronises rx, validates the start bit,
// majority-votes each bit and holds the byte in a valid/ready register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned DIV      = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic        PAR_ODD  = (PARITY_ODD != 0);

  state_e               state_q, state_d;
  logic [2:0]           sync_q, sync_d;   // [0],[1] synchroniser, [2] previous rx_s
  logic [3:0]           s_q, s_d;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 parerr_q, parerr_d;
  logic                 ovr_q, ovr_d;

  logic rx_s, rx_prev, tick, restart, vote, complete, load;

  uart_os_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sync_d   = {sync_q[1:0], rx};
    state_d  = state_q;
    s_d      = s_q;
    bit_d    = bit_q;
    samp_d   = samp_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = ferr_q;
    parerr_d = parerr_q;
    ovr_d    = 1'b0;
    restart  = 1'b0;
    complete = 1'b0;

    rx_s    = sync_q[1];
    rx_prev = sync_q[2];
    vote    = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);

    if (state_q != ST_IDLE && tick) begin
      s_d = s_q + 4'd1;
      if (s_q == S_VOTE_A) samp_d[0] = rx_s;
      if (s_q == S_VOTE_B) samp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d = ST_START;
          s_d     = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (tick && s_q == S_VOTE_C && vote) state_d = ST_IDLE;  // glitch, not a start bit
        else if (tick && s_q == S_END)       state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick && s_q == S_VOTE_C) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
        if (tick && s_q == S_END) begin
          if (bit_q == LAST_BIT) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          else                   bit_d   = bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (tick && s_q == S_VOTE_C) perr_d = vote ^ (^shreg_q) ^ PAR_ODD;
        if (tick && s_q == S_END)    state_d = ST_STOP;
      end
      ST_STOP: begin
        // Leave half a bit early so the next start edge is never missed.
        if (tick && s_q == S_VOTE_C) begin
          complete = 1'b1;
          state_d  = vote ? ST_IDLE : ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    load = complete && (!valid_q || rx_ready);
    if (load) begin
      data_d   = shreg_q;
      ferr_d   = ~vote;
      parerr_d = (PARITY_EN != 0) && perr_q;
      valid_d  = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d  = 1'b0;
    end
    ovr_d = complete && valid_q && !rx_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sync_q   <= 3'b111;  // line idles high, so no false edge leaves reset
      s_q      <= '0;
      bit_q    <= '0;
      samp_q   <= '0;
      shreg_q  <= '0;
      perr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      parerr_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      s_q      <= s_d;
      bit_q    <= bit_d;
      samp_q   <= samp_d;
      shreg_q  <= shreg_d;
      perr_q   <= perr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      parerr_q <= parerr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data_out    = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign parity_err  = parerr_q;
  assign overrun_err = ovr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
